// File: rtl/aim_loader_pkg.sv
// Shared constants, state encoding and length check for the AIM program loader.
// Imported by the interface, the checksum register and the loader top.
package aim_loader_pkg;

    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_VERIFY,
        ST_DRAIN,
        ST_DONE,
        ST_ERROR
    } loaderState_e;

    // A load must cover at least one byte and may not run past the last address.
    function automatic logic lengthLegal(input logic [LEN_W-1:0] len);
        return (len != '0) && (len <= LEN_W'(DEPTH));
    endfunction

endpackage

// File: rtl/aim_program_loader_if.sv
// Host stream, memory bus and status signals of the AIM program loader.
// The loader takes the master modport; the host/memory side takes the slave modport.
interface aim_program_loader_if;
    import aim_loader_pkg::*;

    logic              Start;
    logic [LEN_W-1:0]  Length;
    logic [DATA_W-1:0] InByte;
    logic              InValid;
    logic              InReady;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] WriteData;
    logic              WAIM;
    logic              RAIM;
    logic              InitAIM;
    logic [DATA_W-1:0] ReadData;
    logic              Busy;
    logic              Done;
    logic              Error;
    logic [DATA_W-1:0] Checksum;

    modport master (
        input  Start, Length, InByte, InValid, ReadData,
        output InReady, Addr, WriteData, WAIM, RAIM, InitAIM,
               Busy, Done, Error, Checksum
    );

    modport slave (
        output Start, Length, InByte, InValid, ReadData,
        input  InReady, Addr, WriteData, WAIM, RAIM, InitAIM,
               Busy, Done, Error, Checksum
    );

endinterface

// File: rtl/aim_checksum8.sv
// 8-bit clear/accumulate register; the sum wraps modulo 256.
// Clear has priority over accumulate so a restart never folds in a stale byte.
module aim_checksum8
    import aim_loader_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              clear_i,
    input  logic              accEn_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] sum_o
);

    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clear_i) begin
            sum_d = '0;
        end else if (accEn_i) begin
            sum_d = sum_q + data_i;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/aim_program_loader.sv
// Clears the instruction memory, streams a byte image into it from address 0,
// then reads it back and checks the modulo-256 sum against the loaded bytes.
module aim_program_loader
    import aim_loader_pkg::*;
(
    input  logic Clk,
    input  logic Rst,
    aim_program_loader_if.master bus
);

    loaderState_e      state_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  wcnt_q;
    logic [LEN_W-1:0]  rcnt_q;
    logic              drain_q;
    logic              sampleEn_q;
    logic              inReady_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              waim_q;
    logic              raim_q;
    logic              init_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;

    logic              startSeen;
    logic              startLegal;
    logic              accept;
    logic [DATA_W-1:0] loadSum;
    logic [DATA_W-1:0] verifySum;

    assign startSeen  = bus.Start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                      (state_q == ST_ERROR));
    assign startLegal = startSeen && lengthLegal(bus.Length);
    assign accept     = (state_q == ST_LOAD) && inReady_q && bus.InValid;

    aim_checksum8 loadSumReg (
        .Clk     (Clk),
        .Rst     (Rst),
        .clear_i (startLegal),
        .accEn_i (accept),
        .data_i  (bus.InByte),
        .sum_o   (loadSum)
    );

    // ReadData for a read issued at edge k is valid between k+1 and k+2, so the
    // verify sum samples it one cycle behind the RAIM pulse.
    aim_checksum8 verifySumReg (
        .Clk     (Clk),
        .Rst     (Rst),
        .clear_i (startLegal),
        .accEn_i (sampleEn_q),
        .data_i  (bus.ReadData),
        .sum_o   (verifySum)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            drain_q    <= 1'b0;
            sampleEn_q <= 1'b0;
            inReady_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            waim_q     <= 1'b0;
            raim_q     <= 1'b0;
            init_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            waim_q     <= 1'b0;
            raim_q     <= 1'b0;
            init_q     <= 1'b0;
            sampleEn_q <= raim_q;

            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (startLegal) begin
                        len_q   <= bus.Length;
                        wcnt_q  <= '0;
                        rcnt_q  <= '0;
                        drain_q <= 1'b0;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        init_q  <= 1'b1;
                        state_q <= ST_CLEAR;
                    end else if (startSeen) begin
                        done_q  <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= ST_ERROR;
                    end
                end

                ST_CLEAR: begin
                    inReady_q <= 1'b1;
                    state_q   <= ST_LOAD;
                end

                // Addr and WriteData hold their last values while the stream stalls.
                ST_LOAD: begin
                    if (accept) begin
                        waim_q  <= 1'b1;
                        addr_q  <= wcnt_q[ADDR_W-1:0];
                        wdata_q <= bus.InByte;
                        wcnt_q  <= wcnt_q + 10'd1;
                        if (wcnt_q == (len_q - 10'd1)) begin
                            inReady_q <= 1'b0;
                            state_q   <= ST_VERIFY;
                        end
                    end
                end

                ST_VERIFY: begin
                    if (rcnt_q < len_q) begin
                        raim_q <= 1'b1;
                        addr_q <= rcnt_q[ADDR_W-1:0];
                        rcnt_q <= rcnt_q + 10'd1;
                    end else begin
                        drain_q <= 1'b0;
                        state_q <= ST_DRAIN;
                    end
                end

                // Two cycles let the final read reach the verify sum before comparing.
                ST_DRAIN: begin
                    if (!drain_q) begin
                        drain_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        if (verifySum != loadSum) begin
                            error_q <= 1'b1;
                            state_q <= ST_ERROR;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.InReady   = inReady_q;
    assign bus.Addr      = addr_q;
    assign bus.WriteData = wdata_q;
    assign bus.WAIM      = waim_q;
    assign bus.RAIM      = raim_q;
    assign bus.InitAIM   = init_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Error     = error_q;
    assign bus.Checksum  = loadSum;

endmodule

// File: tb/tb_aim_program_loader.sv
// Directed bench for the AIM program loader with a behavioural 512x8 memory
// that can corrupt address 1 on read-back.
module tb_aim_program_loader;
    import aim_loader_pkg::*;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    aim_program_loader_if bus();

    aim_program_loader dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    logic [7:0] mem     [0:511];
    logic [7:0] dataBuf [0:511];
    bit         corruptEn = 1'b0;

    // Memory with registered read data; corruption flips every bit of address 1.
    always @(posedge Clk) begin
        if (bus.InitAIM) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
        end else if (bus.WAIM) begin
            mem[bus.Addr] <= bus.WriteData;
        end
        if (bus.RAIM) begin
            bus.ReadData <= mem[bus.Addr] ^ ((corruptEn && bus.Addr == 9'd1) ? 8'hFF : 8'h00);
        end
    end

    int checks   = 0;
    int failures = 0;
    int initCnt, wIdx, rIdx, wrErr, rdErr, ovlErr, cycles;
    bit lastAccept;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearMonitor();
        initCnt = 0; wIdx = 0; rIdx = 0;
        wrErr = 0; rdErr = 0; ovlErr = 0; cycles = 0;
        lastAccept = 1'b0;
    endtask

    // Advance to the next falling edge and tally what the bus did after the rising edge.
    task automatic tickCycle();
        @(negedge Clk);
        cycles++;
        if (bus.InitAIM) initCnt++;
        if (bus.WAIM !== lastAccept) wrErr++;
        if (bus.WAIM) begin
            if (wIdx >= 512 || bus.Addr !== wIdx[8:0] || bus.WriteData !== dataBuf[wIdx]) wrErr++;
            wIdx++;
        end
        if (bus.RAIM) begin
            if (bus.Addr !== rIdx[8:0]) rdErr++;
            rIdx++;
        end
        if ((int'(bus.WAIM) + int'(bus.RAIM) + int'(bus.InitAIM)) > 1) ovlErr++;
    endtask

    // Starts a load of dataBuf[0..len-1] and feeds it until Done or the cycle budget runs out.
    task automatic applyStimulus(input int len, input bit gaps, input bit pokeVerify);
        int feedIdx;
        bit poked;
        feedIdx = 0;
        poked   = 1'b0;
        clearMonitor();
        bus.Start   = 1'b1;
        bus.Length  = 10'(len);
        bus.InValid = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            tickCycle();
            if (lastAccept) feedIdx++;
            bus.Start  = 1'b0;
            bus.Length = 10'(len);
            if (pokeVerify && !poked && bus.RAIM) begin
                bus.Start  = 1'b1;
                bus.Length = 10'd2;
                poked      = 1'b1;
            end
            if (bus.Done) break;
            bus.InValid = (feedIdx < len) && (!gaps || $urandom_range(0, 3) != 0);
            bus.InByte  = (feedIdx < len) ? dataBuf[feedIdx] : 8'h00;
            lastAccept  = bus.InValid && bus.InReady;
        end
        bus.Start   = 1'b0;
        bus.InValid = 1'b0;
        lastAccept  = 1'b0;
        checkOutput("done_reached", 32'(bus.Done), 32'd1);
    endtask

    task automatic checkIllegal(input int len, input string tag);
        clearMonitor();
        bus.Start  = 1'b1;
        bus.Length = 10'(len);
        tickCycle();
        bus.Start = 1'b0;
        checkOutput({tag, "_error"}, 32'(bus.Error), 32'd1);
        checkOutput({tag, "_busy"}, 32'(bus.Busy), 32'd0);
        for (int i = 0; i < 3; i++) tickCycle();
        checkOutput({tag, "_strobes"}, 32'(initCnt + wIdx + rIdx), 32'd0);
    endtask

    initial begin
        bus.Start   = 1'b0;
        bus.Length  = '0;
        bus.InByte  = '0;
        bus.InValid = 1'b0;
        clearMonitor();

        repeat (3) @(negedge Clk);
        checkOutput("rst_inready", 32'(bus.InReady), 32'd0);
        checkOutput("rst_busy", 32'(bus.Busy), 32'd0);
        checkOutput("rst_done", 32'(bus.Done), 32'd0);
        checkOutput("rst_error", 32'(bus.Error), 32'd0);
        checkOutput("rst_checksum", 32'(bus.Checksum), 32'd0);
        checkOutput("rst_strobes", {29'd0, bus.WAIM, bus.RAIM, bus.InitAIM}, 32'd0);
        checkOutput("rst_addr", 32'(bus.Addr), 32'd0);
        Rst = 1'b0;
        tickCycle();

        // Four bytes back-to-back: Done lands 2L+5 falling edges after Start.
        dataBuf[0] = 8'h11; dataBuf[1] = 8'h22; dataBuf[2] = 8'h33; dataBuf[3] = 8'h44;
        applyStimulus(4, 1'b0, 1'b0);
        checkOutput("l4_init_cnt", 32'(initCnt), 32'd1);
        checkOutput("l4_writes", 32'(wIdx), 32'd4);
        checkOutput("l4_write_err", 32'(wrErr), 32'd0);
        checkOutput("l4_reads", 32'(rIdx), 32'd4);
        checkOutput("l4_read_err", 32'(rdErr), 32'd0);
        checkOutput("l4_overlap", 32'(ovlErr), 32'd0);
        checkOutput("l4_error", 32'(bus.Error), 32'd0);
        checkOutput("l4_checksum", 32'(bus.Checksum), 32'hAA);
        checkOutput("l4_latency", 32'(cycles), 32'd13);
        checkOutput("l4_busy", 32'(bus.Busy), 32'd0);

        checkIllegal(0, "len0");
        checkIllegal(600, "len600");

        for (int i = 0; i < 512; i++) dataBuf[i] = 8'(i);
        applyStimulus(512, 1'b1, 1'b0);
        checkOutput("l512_writes", 32'(wIdx), 32'd512);
        checkOutput("l512_write_err", 32'(wrErr), 32'd0);
        checkOutput("l512_reads", 32'(rIdx), 32'd512);
        checkOutput("l512_read_err", 32'(rdErr), 32'd0);
        checkOutput("l512_overlap", 32'(ovlErr), 32'd0);
        checkOutput("l512_error", 32'(bus.Error), 32'd0);
        checkOutput("l512_checksum", 32'(bus.Checksum), 32'h00);

        corruptEn  = 1'b1;
        dataBuf[0] = 8'h01; dataBuf[1] = 8'h02; dataBuf[2] = 8'h03;
        applyStimulus(3, 1'b0, 1'b0);
        checkOutput("bad_error", 32'(bus.Error), 32'd1);
        checkOutput("bad_checksum", 32'(bus.Checksum), 32'h06);
        corruptEn = 1'b0;

        // Reset in the middle of LOAD once two bytes have been written.
        for (int i = 0; i < 8; i++) dataBuf[i] = 8'(8'h11 * (i + 1));
        begin
            int feedIdx;
            feedIdx = 0;
            clearMonitor();
            bus.Start  = 1'b1;
            bus.Length = 10'd8;
            for (int c = 0; c < 50; c++) begin
                tickCycle();
                if (lastAccept) feedIdx++;
                bus.Start = 1'b0;
                if (wIdx == 2) break;
                bus.InValid = 1'b1;
                bus.InByte  = dataBuf[feedIdx];
                lastAccept  = bus.InValid && bus.InReady;
            end
            bus.InValid = 1'b0;
            lastAccept  = 1'b0;
            checkOutput("mid_two_writes", 32'(wIdx), 32'd2);
            #2 Rst = 1'b1;
            #1;
            checkOutput("mid_rst_busy", 32'(bus.Busy), 32'd0);
            checkOutput("mid_rst_inready", 32'(bus.InReady), 32'd0);
            checkOutput("mid_rst_checksum", 32'(bus.Checksum), 32'd0);
            checkOutput("mid_rst_strobes", {29'd0, bus.WAIM, bus.RAIM, bus.InitAIM}, 32'd0);
            #2 Rst = 1'b0;
            tickCycle();
        end
        dataBuf[0] = 8'h5A;
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput("after_rst_error", 32'(bus.Error), 32'd0);
        checkOutput("after_rst_checksum", 32'(bus.Checksum), 32'h5A);
        checkOutput("after_rst_latency", 32'(cycles), 32'd7);

        dataBuf[0] = 8'h11; dataBuf[1] = 8'h22; dataBuf[2] = 8'h33; dataBuf[3] = 8'h44;
        applyStimulus(4, 1'b0, 1'b1);
        checkOutput("poke_reads", 32'(rIdx), 32'd4);
        checkOutput("poke_init_cnt", 32'(initCnt), 32'd1);
        checkOutput("poke_checksum", 32'(bus.Checksum), 32'hAA);
        checkOutput("poke_latency", 32'(cycles), 32'd13);
        checkOutput("poke_error", 32'(bus.Error), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
